// File: rtl/latched_bus_transceiver_if.sv
// Control and data signals of the latched bus transceiver. The shared d_bus is
// deliberately not part of this bundle; it stays a direct inout port of the block.
interface latched_bus_transceiver_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             cs_n;
  logic             dce;
  logic             bus_oe;
  logic             rx_valid;
  logic             busy;
  logic [15:0]      xfer_cnt;

  modport master (
    output d_in, cs_n, dce,
    input  d_out, bus_oe, rx_valid, busy, xfer_cnt
  );

  modport slave (
    input  d_in, cs_n, dce,
    output d_out, bus_oe, rx_valid, busy, xfer_cnt
  );
endinterface

// File: rtl/latched_bus_transceiver.sv
// Clocked bidirectional bus transceiver with programmable turnaround dead time.
// Optional RECV capture counter on xfer_cnt is enabled by defining LBT_XFER_COUNT_EN.
module latched_bus_transceiver #(
  parameter int unsigned WIDTH           = 8,
  parameter bit          INVERTED_OUTPUT = 1'b0,
  parameter int unsigned TURNAROUND      = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  latched_bus_transceiver_if.slave        bus_if,
  inout  wire  [WIDTH-1:0]                d_bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StRecv  = 2'd2;
  localparam logic [1:0] StTurn  = 2'd3;

  localparam logic [WIDTH-1:0] InvMask  = {WIDTH{INVERTED_OUTPUT}};
  localparam logic [3:0]       TurnLoad = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_state;
  logic [3:0]       turn_cnt_q, turn_cnt_d;
  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] d_out_q;
  logic             bus_oe_q;
  logic             rx_valid_q;

  // Destination chosen from a quiet state (IDLE or an expired TURN).
  always_comb begin
    sel_state = StIdle;
    if (!bus_if.cs_n) begin
      sel_state = bus_if.dce ? StRecv : StDrive;
    end
  end

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      StIdle: state_d = sel_state;
      StDrive: begin
        if (bus_if.cs_n) begin
          state_d = StIdle;
        end else if (bus_if.dce) begin
          if (TURNAROUND == 0) begin
            state_d = StRecv;
          end else begin
            state_d    = StTurn;
            turn_cnt_d = TurnLoad;
          end
        end
      end
      StRecv: begin
        if (bus_if.cs_n) begin
          state_d = StIdle;
        end else if (!bus_if.dce) begin
          if (TURNAROUND == 0) begin
            state_d = StDrive;
          end else begin
            state_d    = StTurn;
            turn_cnt_d = TurnLoad;
          end
        end
      end
      StTurn: begin
        // cs_n is ignored until the dead time has fully elapsed.
        if (turn_cnt_q == 4'd0) begin
          state_d = sel_state;
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      turn_cnt_q <= 4'd0;
      bus_q      <= '0;
      d_out_q    <= '0;
      bus_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      // Drive only while DRIVE persists; release on the edge that leaves it.
      bus_oe_q   <= (state_q == StDrive) && (state_d == StDrive);
      if (state_q == StDrive) begin
        bus_q <= bus_if.d_in ^ InvMask;
      end
      if (state_q == StRecv) begin
        d_out_q <= d_bus ^ InvMask;
      end
      if ((state_d == StDrive) && (state_q != StDrive)) begin
        rx_valid_q <= 1'b0;
      end else if (state_q == StRecv) begin
        rx_valid_q <= 1'b1;
      end
    end
  end

`ifdef LBT_XFER_COUNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 16'h0000;
    end else if (state_q == StRecv) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign bus_if.xfer_cnt = xfer_cnt_q;
`else
  assign bus_if.xfer_cnt = 16'h0000;
`endif

  assign d_bus           = bus_oe_q ? bus_q : {WIDTH{1'bz}};
  assign bus_if.d_out    = d_out_q;
  assign bus_if.bus_oe   = bus_oe_q;
  assign bus_if.rx_valid = rx_valid_q;
  assign bus_if.busy     = (state_q == StTurn);

endmodule

// File: tb/tb_latched_bus_transceiver.sv
// Bench: two transceivers (true/T=3 and inverted/T=0) share stimulus; a mode-level
// model predicts outputs every cycle, and directed literal checks pin key points.
module tb_latched_bus_transceiver;

  localparam int TA = 3;
  localparam int TB = 0;
  localparam int MIdle  = 0;
  localparam int MDrive = 1;
  localparam int MRecv  = 2;
  localparam int MTurn  = 3;
`ifdef LBT_XFER_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cs_n = 1'b1;
  logic       dce = 1'b0;
  logic [3:0] d_in = 4'h0;
  logic [3:0] ext_val = 4'h0;
  wire  [3:0] bus_a;
  wire  [3:0] bus_b;
  logic       drv_a, drv_b;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_a_cnt, busy_b_cnt;

  int          m_mode [2];
  int          m_dead [2];
  logic [3:0]  m_busq [2];
  logic [3:0]  m_dout [2];
  logic        m_oe   [2];
  logic        m_rxv  [2];
  logic [15:0] m_cnt  [2];

  always #5 clk = ~clk;

  latched_bus_transceiver_if #(.WIDTH(4)) if_a ();
  latched_bus_transceiver_if #(.WIDTH(4)) if_b ();

  assign if_a.d_in = d_in;
  assign if_a.cs_n = cs_n;
  assign if_a.dce  = dce;
  assign if_b.d_in = d_in;
  assign if_b.cs_n = cs_n;
  assign if_b.dce  = dce;

  latched_bus_transceiver #(.WIDTH(4), .INVERTED_OUTPUT(1'b0), .TURNAROUND(TA)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (if_a),
    .d_bus  (bus_a)
  );

  latched_bus_transceiver #(.WIDTH(4), .INVERTED_OUTPUT(1'b1), .TURNAROUND(TB)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (if_b),
    .d_bus  (bus_b)
  );

  // The external side drives the bus whenever the transceiver is expected to be off it.
  assign drv_a = ~m_oe[0];
  assign drv_b = ~m_oe[1];
  assign bus_a = drv_a ? ext_val : 4'bzzzz;
  assign bus_b = drv_b ? ext_val : 4'bzzzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int choose(input logic cs, input logic d);
    if (cs) return MIdle;
    return d ? MRecv : MDrive;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = MIdle;
      m_dead[i] = 0;
      m_busq[i] = 4'h0;
      m_dout[i] = 4'h0;
      m_oe[i]   = 1'b0;
      m_rxv[i]  = 1'b0;
      m_cnt[i]  = 16'h0;
    end
  endtask

  task automatic model_edge(input int i);
    int         nxt;
    int         t;
    logic [3:0] inv;
    t   = (i == 0) ? TA : TB;
    inv = (i == 0) ? 4'h0 : 4'hF;
    nxt = m_mode[i];
    case (m_mode[i])
      MIdle:  nxt = choose(cs_n, dce);
      MDrive: if (cs_n) nxt = MIdle; else if (dce) nxt = (t == 0) ? MRecv : MTurn;
      MRecv:  if (cs_n) nxt = MIdle; else if (!dce) nxt = (t == 0) ? MDrive : MTurn;
      default: nxt = (m_dead[i] == 1) ? choose(cs_n, dce) : MTurn;
    endcase
    if (nxt == MTurn) m_dead[i] = (m_mode[i] == MTurn) ? m_dead[i] - 1 : t;
    if (m_mode[i] == MRecv) begin
      m_dout[i] = ext_val ^ inv;
      m_rxv[i]  = 1'b1;
      if (CntEn) m_cnt[i] = m_cnt[i] + 16'd1;
    end
    if (m_mode[i] == MDrive) m_busq[i] = d_in ^ inv;
    if (nxt == MDrive && m_mode[i] != MDrive) m_rxv[i] = 1'b0;
    m_oe[i]   = (m_mode[i] == MDrive) && (nxt == MDrive);
    m_mode[i] = nxt;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_edge(0);
      model_edge(1);
    end
  end

  task automatic cmp_inst(input int i, input logic oe, input logic busy, input logic rxv,
                          input logic [3:0] dout, input logic [15:0] cnt,
                          input logic [3:0] bus, input logic drv);
    string s;
    s = (i == 0) ? "a" : "b";
    check({s, ".bus_oe"}, oe, m_oe[i]);
    check({s, ".busy"}, busy, (m_mode[i] == MTurn));
    check({s, ".rx_valid"}, rxv, m_rxv[i]);
    check({s, ".d_out"}, dout, m_dout[i]);
    check({s, ".xfer_cnt"}, cnt, m_cnt[i]);
    check({s, ".contention"}, oe & drv, 1'b0);
    if (m_oe[i]) check({s, ".d_bus"}, bus, m_busq[i]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_inst(0, if_a.bus_oe, if_a.busy, if_a.rx_valid, if_a.d_out, if_a.xfer_cnt, bus_a, drv_a);
      cmp_inst(1, if_b.bus_oe, if_b.busy, if_b.rx_valid, if_b.d_out, if_b.xfer_cnt, bus_b, drv_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("rst.a.bus_oe", if_a.bus_oe, 1'b0);
    check("rst.a.d_out", if_a.d_out, 4'h0);
    check("rst.a.rx_valid", if_a.rx_valid, 1'b0);
    check("rst.a.busy", if_a.busy, 1'b0);
    check("rst.b.xfer_cnt", if_b.xfer_cnt, 16'h0);

    // Drive path, true and inverted.
    cs_n = 1'b0; dce = 1'b0; d_in = 4'b0101;
    step(1);
    check("drv.latency.a.bus_oe", if_a.bus_oe, 1'b0);
    step(1);
    check("drv.a.bus_oe", if_a.bus_oe, 1'b1);
    check("drv.a.d_bus", bus_a, 4'b0101);
    check("drv.b.d_bus", bus_b, 4'b1010);
    d_in = 4'b1001;
    step(1);
    check("drv.a.d_bus2", bus_a, 4'b1001);
    check("drv.b.d_bus_inv", bus_b, 4'b0110);
    cs_n = 1'b1;
    step(1);
    check("release.a.bus_oe", if_a.bus_oe, 1'b0);
    check("release.b.bus_oe", if_b.bus_oe, 1'b0);

    // Receive path, then deselect and hold.
    ext_val = 4'b0100; cs_n = 1'b0; dce = 1'b1;
    step(2);
    check("rx.a.d_out", if_a.d_out, 4'b0100);
    check("rx.a.rx_valid", if_a.rx_valid, 1'b1);
    check("rx.b.d_out", if_b.d_out, 4'b1011);
    ext_val = 4'b0001;
    step(1);
    check("rx.b.d_out_inv", if_b.d_out, 4'b1110);
    cs_n = 1'b1;
    step(1);
    ext_val = 4'b1111;
    step(2);
    check("hold.a.d_out", if_a.d_out, 4'b0001);
    check("hold.a.rx_valid", if_a.rx_valid, 1'b1);
    check("hold.b.d_out", if_b.d_out, 4'b1110);

    // DRIVE -> RECV turnaround.
    cs_n = 1'b0; dce = 1'b0; d_in = 4'b0011;
    step(1);
    check("drv_entry.a.rx_valid", if_a.rx_valid, 1'b0);
    step(1);
    dce = 1'b1; ext_val = 4'b0011;
    busy_a_cnt = 0; busy_b_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (k == 0) check("turn.a.oe_drop", if_a.bus_oe, 1'b0);
      busy_a_cnt += int'(if_a.busy);
      busy_b_cnt += int'(if_b.busy);
    end
    check("turn.a.busy_cycles", busy_a_cnt, 3);
    check("turn.b.busy_cycles", busy_b_cnt, 0);
    check("turn.a.d_out", if_a.d_out, 4'b0011);
    check("turn.b.d_out", if_b.d_out, 4'b1100);

    // RECV -> DRIVE turnaround.
    dce = 1'b0;
    busy_a_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      busy_a_cnt += int'(if_a.busy);
    end
    check("turn2.a.busy_cycles", busy_a_cnt, 3);
    check("turn2.a.bus_oe", if_a.bus_oe, 1'b1);
    check("turn2.a.d_bus", bus_a, 4'b0011);
    check("turn2.b.d_bus", bus_b, 4'b1100);
    check("turn2.a.rx_valid", if_a.rx_valid, 1'b0);

    // Deselect and direction flip on the same edge: straight to IDLE.
    cs_n = 1'b1; dce = 1'b1;
    step(1);
    check("prio.a.busy", if_a.busy, 1'b0);
    check("prio.a.bus_oe", if_a.bus_oe, 1'b0);
    check("prio.b.busy", if_b.busy, 1'b0);

    // Deselect during TURN does not shorten the dead time.
    cs_n = 1'b0; dce = 1'b1;
    step(2);
    dce = 1'b0;
    step(1);
    cs_n = 1'b1;
    step(2);
    check("turn_cs.a.busy", if_a.busy, 1'b1);
    step(1);
    check("turn_cs.a.busy_end", if_a.busy, 1'b0);
    check("turn_cs.a.bus_oe", if_a.bus_oe, 1'b0);

    // Asynchronous reset mid-DRIVE.
    cs_n = 1'b0; dce = 1'b0; d_in = 4'b1110;
    step(3);
    check("arst.pre.a.bus_oe", if_a.bus_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.a.bus_oe", if_a.bus_oe, 1'b0);
    check("arst.b.bus_oe", if_b.bus_oe, 1'b0);
    check("arst.a.d_out", if_a.d_out, 4'h0);
    check("arst.b.d_out", if_b.d_out, 4'h0);
    check("arst.a.rx_valid", if_a.rx_valid, 1'b0);
    check("arst.a.xfer_cnt", if_a.xfer_cnt, 16'h0);
    cs_n = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);

    // Capture counter.
    ext_val = 4'b1010; cs_n = 1'b0; dce = 1'b1;
    step(1);
`ifdef LBT_XFER_COUNT_EN
    step(65535);
    check("cnt.a.full", if_a.xfer_cnt, 16'hFFFF);
    step(1);
    check("cnt.a.wrap", if_a.xfer_cnt, 16'h0000);
    check("cnt.b.wrap", if_b.xfer_cnt, 16'h0000);
`else
    step(20);
    check("cnt.a.off", if_a.xfer_cnt, 16'h0000);
    check("cnt.b.off", if_b.xfer_cnt, 16'h0000);
`endif
    cs_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latched_bus_transceiver.md
# latched_bus_transceiver

Clocked, parametrised successor to the 82x6-style bidirectional bus driver in the ISA–CAMAC interface board. It moves data from `d_in` onto the shared bidirectional `d_bus` (read), or from `d_bus` into a holding register on `d_out` (write), under `cs_n`/`dce` control. A turnaround state machine guarantees programmable dead time on the shared bus between release and re-drive, so the bus is never driven from two sides.

## Interface
- `WIDTH`, 8: data path width in bits, 1..32.
- `INVERTED_OUTPUT`, 0: 1 inverts data in both directions (8226 style); 0 passes it true (8216 style).
- `TURNAROUND`, 1: dead cycles before the bus is re-driven after a release caused by a direction change, 0..15.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `d_in` input WIDTH: data to be driven onto the bus.
- `d_out` output WIDTH: registered bus capture.
- `d_bus` inout WIDTH: shared bus, high-Z unless `bus_oe`=1.
- `cs_n` input 1: chip select, active low.
- `dce` input 1: direction, 0 = `d_in`→`d_bus`, 1 = `d_bus`→`d_out`.
- `bus_oe` output 1: registered, high while the block drives `d_bus`.
- `rx_valid` output 1: `d_out` holds a capture made in RECV.
- `busy` output 1: high in TURN.
- `xfer_cnt` output 16: RECV capture count; see Configuration.

## Operation
- States: IDLE, DRIVE, RECV, TURN. `cs_n`/`dce` are sampled on every rising edge.
- IDLE:
  - `cs_n`=0, `dce`=0 → DRIVE.
  - `cs_n`=0, `dce`=1 → RECV.
  - Otherwise stay in IDLE.
- DRIVE:
  - Each edge: `bus_q <= d_in ^ {WIDTH{INVERTED_OUTPUT}}`; `bus_oe`=1; `d_bus = bus_oe ? bus_q : 'z`.
  - `cs_n`=1 → IDLE.
  - `dce`=1 → TURN, or straight to RECV if `TURNAROUND`=0.
- RECV:
  - Each edge: `d_out <= d_bus ^ {WIDTH{INVERTED_OUTPUT}}`; `rx_valid <= 1`.
  - `cs_n`=1 → IDLE; `d_out` and `rx_valid` hold.
  - `dce`=0 → TURN, or straight to DRIVE if `TURNAROUND`=0.
- TURN:
  - `bus_oe`=0 and `busy`=1.
  - Down-counter loaded with `TURNAROUND`-1 on entry.
  - At count 0, next state is chosen from the current `cs_n`/`dce` exactly as from IDLE.
  - `cs_n`=1 during TURN does not abort the count.
- `rx_valid` clears when DRIVE is entered. `d_out` is never cleared except by reset.
- A change of `d_in` during DRIVE appears on `d_bus` after one clock.

## Timing
- Reset values, applied immediately and asynchronously:
  - state IDLE.
  - `bus_oe`=0, so `d_bus` is Z even mid-DRIVE.
  - `d_out`=0, `bus_q`=0.
  - `rx_valid`=0, `busy`=0, `xfer_cnt`=0.
- IDLE → DRIVE: `cs_n` low at edge N, so `bus_oe` and valid `d_bus` appear after edge N+1. Latency is 1 clock.
- IDLE → RECV: the first capture is at edge N+1, so `d_out` is valid after edge N+1.
- DRIVE → RECV with `TURNAROUND`=T≥1:
  - `bus_oe` falls after the edge that samples `dce`=1.
  - There are exactly T cycles with `busy`=1.
  - The first capture is one edge after TURN exits.
- With T=0, `bus_oe` falls on the same edge that RECV is entered. The first capture is at the following edge, so at least one cycle of Z is still guaranteed before the bus is sampled.
- RECV → DRIVE with T≥1: `bus_oe` rises after the T TURN cycles plus one edge. No overlap is possible.
- When `cs_n` and `dce` change on the same edge, `cs_n`=1 has priority and state goes to IDLE without TURN.

## Configuration
- `LBT_XFER_COUNT_EN` defined:
  - `xfer_cnt` increments on every RECV capture edge.
  - Wraps 16'hFFFF→0.
  - Cleared only by reset.
- Not defined: `xfer_cnt` is tied to 0 and no counter logic is synthesised.

## Test plan
- Reset then `WIDTH`=4, `INVERTED_OUTPUT`=0: `cs_n`=0, `dce`=0, `d_in`=4'b0101 → after 1 clock `bus_oe`=1 and `d_bus`=4'b0101. `cs_n`=1 → `d_bus`=Z after 1 clock.
- External bus driver drives 4'b0100 with `cs_n`=0, `dce`=1 → `d_out`=4'b0100 and `rx_valid`=1 one clock after RECV is entered. `cs_n`=1 → `d_out` holds 4'b0100.
- `INVERTED_OUTPUT`=1, `d_in`=4'b1001 in DRIVE → `d_bus`=4'b0110. Bus 4'b0001 in RECV → `d_out`=4'b1110.
- `TURNAROUND`=3: switch `dce` 0→1 while selected → `bus_oe` drops, `busy` is high exactly 3 cycles, then RECV. Monitor asserts no cycle where `bus_oe`=1 and the bench also drives the bus.
- Assert `rst_n`=0 asynchronously mid-DRIVE → `d_bus` goes Z before the next clock edge; all outputs read reset values.
- With `LBT_XFER_COUNT_EN`: preload by 65535 RECV cycles, then one more → `xfer_cnt`=0. Without the macro, `xfer_cnt` stays 0 throughout.
